// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths and output-stage bundle for the operand fetch stage
package core_pkg;

  localparam int XLEN       = 32;
  localparam int PC_W       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rd_write;
  } ex_stage_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// rtl/operand_fetch_scoreboard.sv - per-register busy bits for in-flight writers
module operand_fetch_scoreboard
  import core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_q;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set) set_vec[set_addr] = 1'b1;
    if (clr) clr_vec[clr_addr] = 1'b1;
  end

  // x0 never has a writer, so its bit is masked off on every update
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand read, hazard stall and output stage toward execute
// OPF_FORWARD_EN compiles in the writeback bypass; without it a same-cycle writeback stalls.
module operand_fetch #(
  parameter int XLEN = core_pkg::XLEN,
  parameter int PC_W = core_pkg::PC_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            id_valid,
  output logic                            id_ready,
  input  logic [PC_W-1:0]                 id_pc,
  input  logic [core_pkg::REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [core_pkg::REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                            id_uses_rs1,
  input  logic                            id_uses_rs2,
  input  logic [core_pkg::REG_ADDR_W-1:0] id_rd_addr,
  input  logic                            id_rd_write,
  output logic [core_pkg::REG_ADDR_W-1:0] rs1_addr,
  output logic [core_pkg::REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]                 rs1_data,
  input  logic [XLEN-1:0]                 rs2_data,
  input  logic                            wb_rd_write,
  input  logic [core_pkg::REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]                 wb_rd_data,
  output logic                            ex_valid,
  input  logic                            ex_ready,
  output logic [PC_W-1:0]                 ex_pc,
  output logic [XLEN-1:0]                 ex_rs1_data,
  output logic [XLEN-1:0]                 ex_rs2_data,
  output logic [core_pkg::REG_ADDR_W-1:0] ex_rd_addr,
  output logic                            ex_rd_write
);
  import core_pkg::*;

  ex_stage_t           stage_q;
  logic                stage_valid;
  logic [NUM_REGS-1:0] busy;

  logic src1_live, src2_live;
  logic wb_hit1, wb_hit2;
  logic ex_hit1, ex_hit2, ex_hit_rd;
  logic raw1, raw2, waw, hazard;
  logic accept, out_fire, sb_set;
  logic [XLEN-1:0] op1, op2;

  assign rs1_addr = id_rs1_addr;
  assign rs2_addr = id_rs2_addr;

  always_comb begin
    src1_live = id_uses_rs1 && (id_rs1_addr != '0);
    src2_live = id_uses_rs2 && (id_rs2_addr != '0);
    wb_hit1   = wb_rd_write && (wb_rd_addr == id_rs1_addr);
    wb_hit2   = wb_rd_write && (wb_rd_addr == id_rs2_addr);
    // a writer sitting in the output stage is not yet in the scoreboard
    ex_hit1   = stage_valid && stage_q.rd_write && (stage_q.rd_addr == id_rs1_addr);
    ex_hit2   = stage_valid && stage_q.rd_write && (stage_q.rd_addr == id_rs2_addr);
    ex_hit_rd = stage_valid && stage_q.rd_write && (stage_q.rd_addr == id_rd_addr);
`ifdef OPF_FORWARD_EN
    raw1 = src1_live && ((busy[id_rs1_addr] && !wb_hit1) || ex_hit1);
    raw2 = src2_live && ((busy[id_rs2_addr] && !wb_hit2) || ex_hit2);
`else
    raw1 = src1_live && (busy[id_rs1_addr] || ex_hit1 || wb_hit1);
    raw2 = src2_live && (busy[id_rs2_addr] || ex_hit2 || wb_hit2);
`endif
    waw      = id_rd_write && (id_rd_addr != '0) && (busy[id_rd_addr] || ex_hit_rd);
    hazard   = id_valid && (raw1 || raw2 || waw);
    id_ready = !rst && !flush && !hazard && (!stage_valid || ex_ready);
    accept   = id_valid && id_ready;
    out_fire = stage_valid && ex_ready && !flush;
    sb_set   = out_fire && stage_q.rd_write && (stage_q.rd_addr != '0);

    op1 = (id_rs1_addr == '0) ? '0 : rs1_data;
    op2 = (id_rs2_addr == '0) ? '0 : rs2_data;
`ifdef OPF_FORWARD_EN
    if (id_rs1_addr != '0 && wb_hit1) op1 = wb_rd_data;
    if (id_rs2_addr != '0 && wb_hit2) op2 = wb_rd_data;
`endif
  end

`ifndef OPF_FORWARD_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_q     <= '0;
    end else if (flush) begin
      stage_valid <= 1'b0;
    end else if (accept) begin
      stage_valid <= 1'b1;
      stage_q     <= '{pc: id_pc, rs1_data: op1, rs2_data: op2,
                       rd_addr: id_rd_addr, rd_write: id_rd_write};
    end else if (stage_valid && ex_ready) begin
      stage_valid <= 1'b0;
    end
  end

  operand_fetch_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set      (sb_set),
    .set_addr (stage_q.rd_addr),
    .clr      (wb_rd_write),
    .clr_addr (wb_rd_addr),
    .busy     (busy)
  );

  assign ex_valid    = stage_valid;
  assign ex_pc       = stage_q.pc;
  assign ex_rs1_data = stage_q.rs1_data;
  assign ex_rs2_data = stage_q.rs2_data;
  assign ex_rd_addr  = stage_q.rd_addr;
  assign ex_rd_write = stage_q.rd_write;

endmodule
